// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: FSM encoding and divider constants shared by the divider blocks.
package div_ctrl_pkg;
    typedef enum logic {IDLE, PENDING} state_t;
    localparam int DEF_DIV = 50_000_000;
    localparam int DEF_MIN_DIV = 2;
endpackage

// File: rtl/div_config_ctrl_if.sv
// div_config_ctrl_if: divisor-change request/acknowledge bus for two requesters.
interface div_config_ctrl_if #(parameter int WIDTH = 28);
    logic req_a;
    logic [WIDTH-1:0] div_a;
    logic req_b;
    logic [WIDTH-1:0] div_b;
    logic ack_a;
    logic ack_b;
    logic err;
    logic busy;
    modport master (output req_a, div_a, req_b, div_b, input ack_a, ack_b, err, busy);
    modport slave (input req_a, div_a, req_b, div_b, output ack_a, ack_b, err, busy);
endinterface

// File: rtl/div_counter.sv
// div_counter: period counter producing tick and a registered divided clock; load swaps divisor and restarts.
module div_counter import div_ctrl_pkg::*; #(
    parameter int WIDTH = 28,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV)
) (
    input logic clk_50M,
    input logic rst_n,
    input logic enable,
    input logic load,
    input logic [WIDTH-1:0] load_div,
    output logic [WIDTH-1:0] cur_div,
    output logic tick,
    output logic clk_out
);
    logic [WIDTH-1:0] count, count_next;
    logic wrap;
    assign wrap = count == cur_div - WIDTH'(1);
    assign tick = enable && wrap;
    assign count_next = wrap ? '0 : count + WIDTH'(1);
    // clk_out is computed from the next count so it lines up with the count it describes
    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) begin
            count <= '0;
            cur_div <= DEFAULT_DIV;
            clk_out <= 1'b0;
        end else if (load) begin
            count <= '0;
            cur_div <= load_div;
            clk_out <= 1'b0;
        end else if (enable) begin
            count <= count_next;
            clk_out <= count_next >= (cur_div >> 1);
        end
endmodule

// File: rtl/div_config_ctrl.sv
// div_config_ctrl: arbitrates divisor-change requests from A and B and applies them at period boundaries.
module div_config_ctrl import div_ctrl_pkg::*; #(
    parameter int WIDTH = 28,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV),
    parameter logic [WIDTH-1:0] MIN_DIV = WIDTH'(DEF_MIN_DIV)
) (
    input logic clk_50M,
    input logic rst_n,
    input logic run,
    div_config_ctrl_if.slave bus,
    output logic [WIDTH-1:0] cur_div,
    output logic tick,
    output logic clk_out
);
    state_t state, state_next;
    logic [WIDTH-1:0] shadow, shadow_next, win_div;
    logic grant_a, grant_b, accept, load, err_next;
    // a request still high during its own ack cycle is not a new request
    assign grant_a = state == IDLE && bus.req_a && !bus.ack_a;
    assign grant_b = state == IDLE && !grant_a && bus.req_b && !bus.ack_b;
    assign bus.busy = state == PENDING;
    always_comb begin
        win_div = grant_a ? bus.div_a : bus.div_b;
        accept = (grant_a || grant_b) && win_div >= MIN_DIV;
        err_next = (grant_a || grant_b) && !accept;
        load = state == PENDING && (tick || !run);
        state_next = accept ? PENDING : load ? IDLE : state;
        shadow_next = accept ? win_div : shadow;
    end
    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            shadow <= DEFAULT_DIV;
            bus.ack_a <= 1'b0;
            bus.ack_b <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            state <= state_next;
            shadow <= shadow_next;
            bus.ack_a <= grant_a;
            bus.ack_b <= grant_b;
            bus.err <= err_next;
        end
    div_counter #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_counter (
        .clk_50M(clk_50M),
        .rst_n(rst_n),
        .enable(run),
        .load(load),
        .load_div(shadow),
        .cur_div(cur_div),
        .tick(tick),
        .clk_out(clk_out)
    );
endmodule

// File: doc/div_config_ctrl.md
DIV_CONFIG_CTRL -- requirements
Module: div_config_ctrl

Interface
REQ-001 Parameter WIDTH, default 28, SHALL set the counter and divisor width.
REQ-002 Parameter DEFAULT_DIV, default 28'd50_000_000, SHALL be the divisor in effect after reset.
REQ-003 Parameter MIN_DIV, default 2, SHALL be the smallest divisor accepted.
REQ-004 clk_50M  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 run  in  1  SHALL enable the divider counter when high.
REQ-007 req_a  in  1  SHALL be the requester A divisor-change request, level, held until ack_a.
REQ-008 div_a  in  WIDTH  SHALL be the requested divisor for A, stable while req_a is high.
REQ-009 req_b  in  1  SHALL be the requester B request, same rules as req_a.
REQ-010 div_b  in  WIDTH  SHALL be the requested divisor for B.
REQ-011 ack_a  out  1  SHALL be a one-cycle acceptance or rejection pulse to A.
REQ-012 ack_b  out  1  SHALL be a one-cycle acceptance or rejection pulse to B.
REQ-013 err  out  1  SHALL pulse with ack_a or ack_b when that request is rejected.
REQ-014 busy  out  1  SHALL be high while a divisor change is pending.
REQ-015 cur_div  out  WIDTH  SHALL be the divisor currently in effect.
REQ-016 tick  out  1  SHALL be a one-cycle pulse at each period end.
REQ-017 clk_out  out  1  SHALL be the divided clock.

Function
REQ-018 The counter SHALL increment when run=1; at counter==cur_div-1 it SHALL wrap to 0 and tick SHALL be high that cycle.
REQ-019 When run=0, the counter, clk_out and cur_div SHALL hold, and tick SHALL be 0.
REQ-020 clk_out SHALL be registered as 0 when counter < cur_div/2 (floor), else 1: odd D gives floor(D/2) low and ceil(D/2) high; D=2 gives 1 low, 1 high.
REQ-021 The FSM SHALL have the states IDLE and PENDING; busy = (state==PENDING).
REQ-022 In IDLE, a request SHALL be arbitrated the same cycle: A has fixed priority over B when both are high; the loser SHALL stay unacknowledged.
REQ-023 Winner with div >= MIN_DIV: shadow <= div, ack pulse on the next cycle, state -> PENDING.
REQ-024 Winner with div < MIN_DIV: ack and err pulse on the next cycle; shadow, cur_div and state SHALL remain unchanged.
REQ-025 In PENDING, requests SHALL NOT be arbitrated or acknowledged.
REQ-026 In PENDING with run=1, at the wrap cycle cur_div <= shadow and counter <= 0, then state -> IDLE; no partial period with mixed divisors SHALL occur.
REQ-027 In PENDING with run=0, the change SHALL apply on the next edge (cur_div <= shadow, counter <= 0, clk_out <= 0), then state -> IDLE.
REQ-028 A requester that holds req after its ack SHALL be treated as a new request once IDLE; requesters SHALL drop req in the cycle after ack.
REQ-029 Accepting a divisor equal to cur_div SHALL still follow REQ-026/027, so busy toggles.
REQ-030 The invariant counter < cur_div SHALL hold in every cycle.

Reset
REQ-031 While rst_n=0, the block SHALL be in this state: counter=0, cur_div=DEFAULT_DIV, shadow=DEFAULT_DIV, state=IDLE, clk_out=0, tick=0, ack_a=0, ack_b=0, err=0, busy=0.
REQ-032 Reset asserted in PENDING SHALL discard the pending divisor; no ack SHALL be re-issued after release.
REQ-033 The first count SHALL occur on the first rising edge after rst_n rises with run=1.

Structure
REQ-034 The FSM state encoding and the MIN_DIV and DEFAULT_DIV constants SHALL live in a shared package, div_ctrl_pkg.
REQ-035 The counter, tick and clk_out logic SHALL be one sub-module, div_counter, with load and enable inputs; the arbiter and FSM SHALL stay in div_config_ctrl.

Verification (sim with WIDTH=8, DEFAULT_DIV=4)
REQ-036 Reset release, run=1 -> tick every 4 cycles; clk_out pattern 0,0,1,1; cur_div=4.
REQ-037 req_a with div_a=6 mid-period -> ack_a after 1 cycle, busy until the wrap; next period 6 cycles with 3 low and 3 high.
REQ-038 req_a(div_a=5) and req_b(div_b=3) in the same cycle -> A acked first, then B acked once IDLE after A applies; final cur_div=3.
REQ-039 req_b with div_b=1 -> ack_b and err together, busy stays 0, cur_div unchanged.
REQ-040 run=0, accept div=7 -> applied on the next cycle with counter=0; run=1 -> 3 low and 4 high cycles.
REQ-041 rst_n pulsed low during PENDING -> all outputs at their reset values and cur_div=4 after release.
